// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU.
//   OP_*    : 3-bit operation select codes
//   state_t : FSM state encoding (ST_IDLE, ST_DIV, ST_DONE)
// Optional feature macro used by the consuming files: ALU_SEQ_DIV_EN.
package alu_seq_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_GT   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div -- W-bit unsigned restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load dividend/divisor and begin (divisor assumed non-zero)
//   dividend  : W-bit numerator
//   divisor   : W-bit denominator
//   done      : high during the last iteration cycle
//   quotient  : result of the current iteration (final value while done=1)
//   remainder : partial remainder after the current iteration
// Only instantiated when ALU_SEQ_DIV_EN is defined.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [W:0]    part_s;
  logic [W:0]    diff_s;

  // Iteration step: shift the next dividend bit into the remainder and try a subtract.
  always_comb begin
    part_s = {rem_q, quo_q[W-1]};
    diff_s = part_s - {1'b0, dsr_q};
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      // The quotient register doubles as the dividend shift register.
      quo_d  = dividend;
      rem_d  = {W{1'b0}};
      dsr_d  = divisor;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff_s[W]) begin
        rem_d = diff_s[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        // Restore: the remainder is less than the divisor, so it fits in W bits.
        rem_d = part_s[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      if (cnt_q == {CW{1'b0}}) begin
        cnt_d  = {CW{1'b0}};
        busy_d = 1'b0;
      end else begin
        cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= {W{1'b0}};
      rem_q  <= {W{1'b0}};
      dsr_q  <= {W{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // The final step's outcome is presented combinationally so the parent can
  // capture it on the same edge that finishes the division.
  assign done      = busy_q && (cnt_q == {CW{1'b0}});
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential W-bit ALU with valid/ready handshakes on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, ops captured on acceptance)
//   a, b                : W-bit unsigned operands
//   ops                 : operation select (see alu_seq_pkg OP_*)
//   out_valid/out_ready : result handshake
//   R                   : W+1-bit registered result
//   err                 : divide/modulo by zero, or op compiled out
// Macro ALU_SEQ_DIV_EN: when defined, DIV/MOD use the multi-cycle divider;
// when undefined, DIV/MOD complete in one cycle with R=0, err=1.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ops,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   R,
  output logic         err
);

  state_t       state_q, state_d;
  logic [W:0]   r_q, r_d;
  logic         err_q, err_d;
  logic         out_valid_q, out_valid_d;
  logic         load_new_s;
  logic [W:0]   sc_r_s;
  logic         sc_err_s;

`ifdef ALU_SEQ_DIV_EN
  logic [2:0]   op_q, op_d;
  logic         go_div_s;
  logic         div_start_s;
  logic         div_done_s;
  logic [W-1:0] div_quo_s;
  logic [W-1:0] div_rem_s;

  alu_seq_div #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_s),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Only a non-zero divisor needs the iterative path.
  assign go_div_s = ((ops == OP_DIV) || (ops == OP_MOD)) && (b != {W{1'b0}});
`endif

  // Single-cycle datapath, including the divide-by-zero and compiled-out results.
  always_comb begin
    sc_r_s   = {(W+1){1'b0}};
    sc_err_s = 1'b0;
    case (ops)
      OP_PASS: sc_r_s = {1'b0, a};
      OP_ADD:  sc_r_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  sc_r_s = {1'b0, a} - {1'b0, b};
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        sc_r_s   = {1'b0, {W{1'b1}}};
        sc_err_s = 1'b1;
      end
      OP_MOD: begin
        sc_r_s   = {1'b0, a};
        sc_err_s = 1'b1;
      end
`else
      OP_DIV, OP_MOD: begin
        sc_r_s   = {(W+1){1'b0}};
        sc_err_s = 1'b1;
      end
`endif
      OP_SHL:  sc_r_s = {a, 1'b0};
      OP_SHR:  sc_r_s = {2'b00, a[W-1:1]};
      OP_GT:   sc_r_s = {{W{1'b0}}, (a > b)};
      default: sc_r_s = {(W+1){1'b0}};
    endcase
  end

  // Ready is combinational from state so a consumed result can overlap a new accept.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    load_new_s  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    op_d        = op_q;
    div_start_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        load_new_s = in_valid;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          load_new_s  = in_valid;
        end else begin
          load_new_s  = 1'b0;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        if (div_done_s) begin
          state_d     = ST_DONE;
          r_d         = (op_q == OP_DIV) ? {1'b0, div_quo_s} : {1'b0, div_rem_s};
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d     = ST_DIV;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (load_new_s) begin
`ifdef ALU_SEQ_DIV_EN
      if (go_div_s) begin
        state_d     = ST_DIV;
        op_d        = ops;
        div_start_s = 1'b1;
        out_valid_d = 1'b0;
      end else begin
        state_d     = ST_DONE;
        r_d         = sc_r_s;
        err_d       = sc_err_s;
        out_valid_d = 1'b1;
      end
`else
      state_d     = ST_DONE;
      r_d         = sc_r_s;
      err_d       = sc_err_s;
      out_valid_d = 1'b1;
`endif
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_q         <= {(W+1){1'b0}};
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_q        <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_DIV_EN
      op_q        <= op_d;
`endif
    end
  end

  assign R         = r_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- directed and randomised checks of alu_seq at W=4.
// Expected results come from an arithmetic reference model that follows
// the ALU_SEQ_DIV_EN setting of the build.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   ops;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   r;
  logic         err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ops       (ops),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (r),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic on integers.
  function automatic int mdl_r(input int op, input int ia, input int ib);
    int m;
    m = 1 << (W + 1);
    case (op)
      0: return ia;
      1: return ia + ib;
      2: return (ia - ib + m) % m;
`ifdef ALU_SEQ_DIV_EN
      3: return (ib == 0) ? (1 << W) - 1 : ia / ib;
      4: return (ib == 0) ? ia : ia % ib;
`else
      3: return 0;
      4: return 0;
`endif
      5: return (ia * 2) % m;
      6: return ia / 2;
      7: return (ia > ib) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int mdl_err(input int op, input int ib);
    if (op == 3 || op == 4) begin
`ifdef ALU_SEQ_DIV_EN
      return (ib == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return 0;
  endfunction

  function automatic int mdl_lat(input int op, input int ib);
`ifdef ALU_SEQ_DIV_EN
    if ((op == 3 || op == 4) && ib != 0) return W + 1;
`endif
    return 1;
  endfunction

  // One transaction: offer, accept, wait for result, optionally stall, consume.
  task automatic run_op(input string tag, input int op, input int ia, input int ib,
                        input int hold, input int exp_r, input int exp_err, input int exp_lat);
    int cyc;
    logic [W:0] held;
    @(negedge clk);
    check({tag, "/ready_pre"}, {31'd0, in_ready}, 32'd1);
    ops       = op[2:0];
    a         = ia[W-1:0];
    b         = ib[W-1:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    // Scramble the operand bus: the captured values must be used.
    in_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    ops = 3'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      check({tag, "/busy_ready"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "/latency"}, cyc, exp_lat);
    check({tag, "/R"}, {27'd0, r}, exp_r);
    check({tag, "/err"}, {31'd0, err}, exp_err);
    held = r;
    for (int i = 0; i < hold; i++) begin
      check({tag, "/stall_ready"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check({tag, "/stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/stall_R"}, {27'd0, r}, {27'd0, held});
    end
    out_ready = 1'b1;
    #1;
    check({tag, "/ready_consume"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check({tag, "/consumed"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int op, ia, ib, hold;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ops       = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/R", {27'd0, r}, 32'd0);
    check("rst/err", {31'd0, err}, 32'd0);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle/no_valid", {31'd0, out_valid}, 32'd0);
    end

    // ADD 14+7 with carry
    run_op("add14_7", 1, 14, 7, 0, 5'b10101, 0, 1);

    // Back-to-back SUB 14-7 then 7-14
    @(negedge clk);
    ops = 3'd2; a = 4'd14; b = 4'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("b2b/valid1", {31'd0, out_valid}, 32'd1);
    check("b2b/R1", {27'd0, r}, 32'b00111);
    check("b2b/ready1", {31'd0, in_ready}, 32'd1);
    ops = 3'd2; a = 4'd7; b = 4'd14;
    @(posedge clk); #1;
    check("b2b/valid2", {31'd0, out_valid}, 32'd1);
    check("b2b/R2", {27'd0, r}, 32'b11001);
    check("b2b/ready2", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b/drained", {31'd0, out_valid}, 32'd0);

`ifdef ALU_SEQ_DIV_EN
    run_op("div14_4", 3, 14, 4, 0, 3, 0, 5);
    run_op("mod14_4", 4, 14, 4, 0, 2, 0, 5);
    run_op("div9_0", 3, 9, 0, 0, 5'b01111, 1, 1);
    run_op("mod9_0", 4, 9, 0, 0, 5'b01001, 1, 1);
`else
    run_op("div14_7_off", 3, 14, 7, 0, 0, 1, 1);
    run_op("mod14_4_off", 4, 14, 4, 0, 0, 1, 1);
    run_op("div9_0_off", 3, 9, 0, 0, 0, 1, 1);
`endif

    // Backpressure on SHL
    run_op("shl_bp", 5, 14, 0, 3, 5'b11100, 0, 1);

    // Reset during the second divide cycle of 15/1
    @(negedge clk);
    ops = 3'd3; a = 4'd15; b = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstmid/out_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid/R", {27'd0, r}, 32'd0);
    check("rstmid/err", {31'd0, err}, 32'd0);
    check("rstmid/in_ready", {31'd0, in_ready}, 32'd1);
    #1 rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      check("rstmid/no_valid", {31'd0, out_valid}, 32'd0);
    end

    // Randomised operations against the model
    for (int i = 0; i < 40; i++) begin
      op   = int'($urandom_range(0, 7));
      ia   = int'($urandom_range(0, 15));
      ib   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 2));
      run_op("rnd", op, ia, ib, hold, mdl_r(op, ia, ib), mdl_err(op, ib), mdl_lat(op, ib));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
